// File: rtl/aabb_nearest_hit_scheduler_pkg.sv
// Shared types for the AABB nearest-hit scheduler and its datapath.
//  Fixed      : signed 16.16 fixed point
//  Ray        : origin, direction, precomputed 1/direction, MaxT (<0 = unbounded), own primitive index
//  AABB       : min/max corners
//  HitData    : hit flag, distance, primitive index, entry normal, colour, surface type
//  AabbSchedState : scheduler FSM states
package aabb_nearest_hit_scheduler_pkg;

  localparam int unsigned FIXED_FRAC = 16;

  typedef logic signed [31:0] Fixed;

  localparam Fixed FIXED_ONE = 32'sh0001_0000;
  localparam Fixed FIXED_MIN = 32'sh8000_0000;
  localparam Fixed FIXED_MAX = 32'sh7fff_ffff;

  typedef logic [15:0] PrimIndex;
  localparam PrimIndex NULL_PRIMITIVE_INDEX = 16'hFFFF;

  typedef struct packed {
    Fixed x;
    Fixed y;
    Fixed z;
  } Vector3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } RGB8;

  typedef enum logic [1:0] {
    ST_None,
    ST_Lambert,
    ST_Mirror,
    ST_Emissive
  } SurfaceType;

  typedef struct packed {
    Vector3   Orig;
    Vector3   Dir;
    Vector3   InvDir;
    Fixed     MaxT;
    PrimIndex PI;
  } Ray;

  typedef struct packed {
    Vector3 Min;
    Vector3 Max;
  } AABB;

  typedef struct packed {
    logic       bHit;
    Fixed       T;
    PrimIndex   PI;
    Vector3     Normal;
    RGB8        Color;
    SurfaceType Surface;
  } HitData;

  typedef enum logic [1:0] {
    ASS_Idle,
    ASS_Issue,
    ASS_Drain,
    ASS_Done
  } AabbSchedState;

  function automatic HitData null_hit();
    HitData h;
    h         = '0;
    h.PI      = NULL_PRIMITIVE_INDEX;
    h.Surface = ST_None;
    return h;
  endfunction

endpackage

// File: rtl/AABBHit.sv
// Combinational ray/box slab test.
//  i_ray   : ray (uses InvDir for slab distances, Dir for axis-parallel detection)
//  i_aabb  : box under test
//  i_pi    : primitive index of the box
//  i_color : box colour, passed through on hit
//  i_st    : box surface type, passed through on hit
//  o_hit   : hit record; bHit=0 on miss, MaxT prune, self-hit or NULL index
module AABBHit
  import aabb_nearest_hit_scheduler_pkg::*;
(
  input  Ray         i_ray,
  input  AABB        i_aabb,
  input  PrimIndex   i_pi,
  input  RGB8        i_color,
  input  SurfaceType i_st,
  output HitData     o_hit
);

  typedef struct packed {
    Fixed lo;
    Fixed hi;
    logic outside;
  } Slab;

  function automatic Fixed fx_mul(input Fixed a, input Fixed b);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return Fixed'(p >>> FIXED_FRAC);
  endfunction

  // Axis-parallel rays have no usable 1/d; they only need the origin inside the slab.
  function automatic Slab slab(input Fixed o, input Fixed d, input Fixed inv,
                               input Fixed mn, input Fixed mx);
    Slab  s;
    Fixed t0;
    Fixed t1;
    s.lo      = FIXED_MIN;
    s.hi      = FIXED_MAX;
    s.outside = 1'b0;
    if (d == '0) begin
      s.outside = (o < mn) || (o > mx);
    end else begin
      t0 = fx_mul(mn - o, inv);
      t1 = fx_mul(mx - o, inv);
      if (t0 <= t1) begin
        s.lo = t0;
        s.hi = t1;
      end else begin
        s.lo = t1;
        s.hi = t0;
      end
    end
    return s;
  endfunction

  Slab        w_sx, w_sy, w_sz;
  Fixed       w_tnear, w_tfar, w_t;
  logic [1:0] w_axis;
  logic       w_hit;
  Vector3     w_n;
  Fixed       w_nsign;

  always_comb begin
    w_sx = slab(i_ray.Orig.x, i_ray.Dir.x, i_ray.InvDir.x, i_aabb.Min.x, i_aabb.Max.x);
    w_sy = slab(i_ray.Orig.y, i_ray.Dir.y, i_ray.InvDir.y, i_aabb.Min.y, i_aabb.Max.y);
    w_sz = slab(i_ray.Orig.z, i_ray.Dir.z, i_ray.InvDir.z, i_aabb.Min.z, i_aabb.Max.z);

    // Entry axis is the one with the latest slab entry; earlier axis wins ties.
    w_tnear = w_sx.lo;
    w_axis  = 2'd0;
    if ($signed(w_sy.lo) > $signed(w_tnear)) begin
      w_tnear = w_sy.lo;
      w_axis  = 2'd1;
    end
    if ($signed(w_sz.lo) > $signed(w_tnear)) begin
      w_tnear = w_sz.lo;
      w_axis  = 2'd2;
    end

    w_tfar = w_sx.hi;
    if ($signed(w_sy.hi) < $signed(w_tfar)) w_tfar = w_sy.hi;
    if ($signed(w_sz.hi) < $signed(w_tfar)) w_tfar = w_sz.hi;

    w_hit = !(w_sx.outside || w_sy.outside || w_sz.outside) &&
            ($signed(w_tnear) <= $signed(w_tfar)) && ($signed(w_tfar) >= 0);

    w_t = ($signed(w_tnear) < 0) ? '0 : w_tnear;

    if (($signed(i_ray.MaxT) >= 0) && ($signed(w_t) > $signed(i_ray.MaxT))) w_hit = 1'b0;
    if ((i_pi == NULL_PRIMITIVE_INDEX) || (i_pi == i_ray.PI)) w_hit = 1'b0;

    w_n     = '0;
    w_nsign = FIXED_ONE;
    case (w_axis)
      2'd0:    if ($signed(i_ray.Dir.x) > 0) w_nsign = -FIXED_ONE;
      2'd1:    if ($signed(i_ray.Dir.y) > 0) w_nsign = -FIXED_ONE;
      default: if ($signed(i_ray.Dir.z) > 0) w_nsign = -FIXED_ONE;
    endcase
    case (w_axis)
      2'd0:    w_n.x = w_nsign;
      2'd1:    w_n.y = w_nsign;
      default: w_n.z = w_nsign;
    endcase

    o_hit = null_hit();
    if (w_hit) begin
      o_hit.bHit    = 1'b1;
      o_hit.T       = w_t;
      o_hit.PI      = i_pi;
      o_hit.Normal  = w_n;
      o_hit.Color   = i_color;
      o_hit.Surface = i_st;
    end
  end

endmodule

// File: rtl/aabb_hit_merge.sv
// Nearest-hit merge: replaces best with cand when cand hits and is strictly
// closer (signed compare), so equal distances keep the earlier primitive.
//  i_best : current best hit
//  i_cand : candidate hit (bHit=0 never merges)
//  o_next : updated best
module aabb_hit_merge
  import aabb_nearest_hit_scheduler_pkg::*;
(
  input  HitData i_best,
  input  HitData i_cand,
  output HitData o_next
);

  always_comb begin
    o_next = i_best;
    if (i_cand.bHit && (!i_best.bHit || ($signed(i_cand.T) < $signed(i_best.T)))) begin
      o_next = i_cand;
    end
  end

endmodule

// File: rtl/aabb_nearest_hit_scheduler.sv
// Walks the primitive AABB table for one ray and returns the nearest hit.
// One table read issued per cycle; stage 1 runs AABBHit on the returned box,
// stage 2 registers the result and merges it into the running best.
//  i_clk, i_resetn      : clock, synchronous active-low reset
//  i_start, i_abort     : begin traversal (IDLE only) / cancel without done
//  i_ray, i_prim_count  : latched on accepted start
//  o_busy, o_done       : busy window / one-cycle completion pulse
//  o_hit_data           : nearest hit, updated only on done
//  o_aabb_rd_en/addr    : table read port
//  i_aabb_rd_aabb/color/st : table data, one cycle after read strobe
module aabb_nearest_hit_scheduler
  import aabb_nearest_hit_scheduler_pkg::*;
#(
  parameter int unsigned MAX_PRIMS = 64,
  parameter int unsigned IDX_W     = $clog2(MAX_PRIMS)
) (
  input  logic                          i_clk,
  input  logic                          i_resetn,
  input  logic                          i_start,
  input  logic                          i_abort,
  input  logic [$bits(Ray)-1:0]         i_ray,
  input  logic [IDX_W:0]                i_prim_count,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [$bits(HitData)-1:0]     o_hit_data,
  output logic                          o_aabb_rd_en,
  output logic [IDX_W-1:0]              o_aabb_rd_addr,
  input  logic [$bits(AABB)-1:0]        i_aabb_rd_aabb,
  input  logic [$bits(RGB8)-1:0]        i_aabb_rd_color,
  input  logic [$bits(SurfaceType)-1:0] i_aabb_rd_st
);

  AabbSchedState  r_state;
  Ray             r_ray;
  logic [IDX_W:0] r_count;
  logic [IDX_W-1:0] r_addr;
  logic           r_rd_en;
  logic           r_busy;
  logic           r_done;
  HitData         r_hit;
  HitData         r_best;
  logic           r_v1;
  logic [IDX_W-1:0] r_pi1;
  logic           r_v2;
  HitData         r_cand;

  AABB        w_aabb;
  RGB8        w_color;
  SurfaceType w_st;
  PrimIndex   w_pi1;
  HitData     w_hit;
  HitData     w_cand;
  HitData     w_next_best;
  logic       w_last;

  assign w_aabb  = AABB'(i_aabb_rd_aabb);
  assign w_color = RGB8'(i_aabb_rd_color);
  assign w_st    = SurfaceType'(i_aabb_rd_st);
  assign w_pi1   = PrimIndex'(r_pi1);
  assign w_last  = ({1'b0, r_addr} == (r_count - (IDX_W+1)'(1)));

  AABBHit u_hit (
    .i_ray   (r_ray),
    .i_aabb  (w_aabb),
    .i_pi    (w_pi1),
    .i_color (w_color),
    .i_st    (w_st),
    .o_hit   (w_hit)
  );

  always_comb begin
    w_cand      = r_cand;
    w_cand.bHit = r_cand.bHit & r_v2;
  end

  aabb_hit_merge u_merge (
    .i_best (r_best),
    .i_cand (w_cand),
    .o_next (w_next_best)
  );

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state <= ASS_Idle;
      r_ray   <= '0;
      r_count <= '0;
      r_addr  <= '0;
      r_rd_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hit   <= null_hit();
      r_best  <= null_hit();
      r_v1    <= 1'b0;
      r_pi1   <= '0;
      r_v2    <= 1'b0;
      r_cand  <= null_hit();
    end else begin
      r_v1   <= r_rd_en;
      r_pi1  <= r_addr;
      r_v2   <= r_v1;
      r_cand <= w_hit;
      r_best <= w_next_best;
      r_done <= 1'b0;

      case (r_state)
        ASS_Idle: begin
          if (i_start) begin
            r_ray   <= Ray'(i_ray);
            r_count <= i_prim_count;
            r_best  <= null_hit();
            r_addr  <= '0;
            r_busy  <= 1'b1;
            if (i_prim_count == '0) begin
              r_state <= ASS_Done;
              r_done  <= 1'b1;
              r_hit   <= null_hit();
            end else begin
              r_state <= ASS_Issue;
              r_rd_en <= 1'b1;
            end
          end
        end
        ASS_Issue: begin
          if (w_last) begin
            r_rd_en <= 1'b0;
            r_state <= ASS_Drain;
          end else begin
            r_addr <= r_addr + IDX_W'(1);
          end
        end
        ASS_Drain: begin
          // Once stage 1 is empty, stage 2 holds the last candidate and merges at
          // this same edge, so the published result takes the merged value.
          if (!r_v1) begin
            r_state <= ASS_Done;
            r_done  <= 1'b1;
            r_hit   <= w_next_best;
          end
        end
        ASS_Done: begin
          r_state <= ASS_Idle;
          r_busy  <= 1'b0;
        end
        default: r_state <= ASS_Idle;
      endcase

      if (i_abort && (r_state != ASS_Idle)) begin
        r_state <= ASS_Idle;
        r_rd_en <= 1'b0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
        r_v1    <= 1'b0;
        r_v2    <= 1'b0;
      end
    end
  end

  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_hit_data     = r_hit;
  assign o_aabb_rd_en   = r_rd_en;
  assign o_aabb_rd_addr = r_addr;

endmodule
